// File: rtl/cr_rbus_master_pkg.sv
// ---------------------------------------------------------------------------
// cr_rbus_master_pkg
// Shared definitions for the rbus ring master:
//   - FSM state encoding
//   - completion status codes
//   - bit positions of the optional statistics pulse vector
// ---------------------------------------------------------------------------
package cr_rbus_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } rbus_mst_state_e;

  localparam logic [1:0] RBUS_ST_OK      = 2'b00;
  localparam logic [1:0] RBUS_ST_NOACK   = 2'b01;
  localparam logic [1:0] RBUS_ST_TIMEOUT = 2'b10;
  localparam logic [1:0] RBUS_ST_RERR    = 2'b11;

  localparam int STAT_OK      = 0;
  localparam int STAT_NOACK   = 1;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_DROP    = 3;

  // Completion status for a matching returned packet.
  function automatic logic [1:0] ring_status(input logic ack, input logic err);
    if (!ack)     return RBUS_ST_NOACK;
    else if (err) return RBUS_ST_RERR;
    else          return RBUS_ST_OK;
  endfunction

endpackage

// File: rtl/cr_structs.sv
// ---------------------------------------------------------------------------
// cr_structs
// Shared ring packet definition used by the rbus master and every regfile
// responder on the register ring.
//   rbus_ring_t : one packet slot on the ring.
//     addr     register address (`N_RBUS_ADDR_BITS wide)
//     wr_strb  write request (packet valid when wr_strb | rd_strb)
//     rd_strb  read request
//     wr_data  write data
//     rd_data  read data filled in by the addressed responder
//     ack      set by the responder whose window decodes addr
//     err      set by the responder when the access failed
// ---------------------------------------------------------------------------
`ifndef N_RBUS_ADDR_BITS
`define N_RBUS_ADDR_BITS 12
`endif

package cr_structs;

  typedef struct packed {
    logic [`N_RBUS_ADDR_BITS-1:0] addr;
    logic                         wr_strb;
    logic                         rd_strb;
    logic [31:0]                  wr_data;
    logic [31:0]                  rd_data;
    logic                         ack;
    logic                         err;
  } rbus_ring_t;

endpackage

// File: rtl/cr_rbus_ring_master_tmo.sv
// ---------------------------------------------------------------------------
// cr_rbus_ring_master_tmo
// Timeout counter for the rbus ring master.
//   clk, rst   : clock, synchronous active-high reset
//   clr_i      : clear the count to zero (has priority over en_i)
//   en_i       : count this cycle
//   expired_o  : high in the enabled cycle in which the count reaches
//                TIMEOUT_CYCLES (i.e. the TIMEOUT_CYCLES-th enabled cycle
//                since the last clear)
// TIMEOUT_CYCLES must lie in 2..65535 and fit in TO_W bits.
// ---------------------------------------------------------------------------
module cr_rbus_ring_master_tmo #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TO_W-1:0] LAST_CNT = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;
  logic            at_last;

  assign at_last   = (cnt_q == LAST_CNT);
  assign expired_o = en_i & at_last;

  // The count saturates at the last value so it can never wrap back into a
  // non-expired range while the enable is still held.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                 cnt_d = '0;
    else if (en_i && !at_last) cnt_d = cnt_q + TO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cr_rbus_ring_master.sv
// ---------------------------------------------------------------------------
// cr_rbus_ring_master
// Initiator and terminator of the rbus register ring. Takes one host
// register request at a time, launches it on the ring for one cycle, waits
// for it to come back around (after every responder regfile has seen it) and
// reports read data plus a completion status.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_valid/ready host request handshake; req_wr, req_addr, req_wdata
//   rsp_valid/ready completion handshake; rsp_rdata, rsp_status
//                   (00 ok, 01 no-ack, 10 timeout, 11 responder error)
//   rbus_ring_o     ring launch (all zero except the single LAUNCH cycle)
//   rbus_ring_i     ring return
//   busy            high whenever the FSM is not in IDLE
//   stat_events     [3:0] event pulses, present only when the macro
//                   CR_RBUS_MASTER_STATS_EN is defined:
//                   [0] ok, [1] no-ack, [2] timeout, [3] dropped return
//
// Handshake rule: a transfer happens on a clk edge where valid and ready are
// both high; valid holds its payload stable until that edge.
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module cr_rbus_ring_master
  import cr_structs::*;
  import cr_rbus_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_wr,
  input  logic [`N_RBUS_ADDR_BITS-1:0] req_addr,
  input  logic [31:0]                  req_wdata,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [31:0]                  rsp_rdata,
  output logic [1:0]                   rsp_status,
  output rbus_ring_t                   rbus_ring_o,
  input  rbus_ring_t                   rbus_ring_i,
  output logic                         busy
`ifdef CR_RBUS_MASTER_STATS_EN
  ,
  output logic [3:0]                   stat_events
`endif
);

  rbus_mst_state_e              state_q;
  logic [`N_RBUS_ADDR_BITS-1:0] addr_q;
  logic                         wr_q;
  rbus_ring_t                   ring_q;
  logic                         req_ready_q;
  logic                         rsp_valid_q;
  logic [31:0]                  rsp_rdata_q;
  logic [1:0]                   rsp_status_q;
  logic                         busy_q;

  rbus_ring_t launch_pkt;
  logic       ret_valid;
  logic       ret_match;
  logic       tmo_expired;

  // Launch packet built from the request inputs so it is on the ring in the
  // very first cycle after the handshake.
  always_comb begin
    launch_pkt         = '0;
    launch_pkt.addr    = req_addr;
    launch_pkt.wr_strb = req_wr;
    launch_pkt.rd_strb = ~req_wr;
    launch_pkt.wr_data = req_wdata;
  end

  // Only our own packet (same address and same access type) completes the
  // transaction; anything else on the return side is swallowed here.
  assign ret_valid = rbus_ring_i.wr_strb | rbus_ring_i.rd_strb;
  assign ret_match = ret_valid
                   && (rbus_ring_i.addr == addr_q)
                   && (rbus_ring_i.wr_strb == wr_q)
                   && (rbus_ring_i.rd_strb == ~wr_q);

  cr_rbus_ring_master_tmo #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_tmo (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_q == LAUNCH),
    .en_i      (state_q == WAIT),
    .expired_o (tmo_expired)
  );

`ifdef CR_RBUS_MASTER_STATS_EN
  logic [3:0] stat_q;
  assign stat_events = stat_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      ring_q       <= '0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_status_q <= RBUS_ST_OK;
      busy_q       <= 1'b0;
`ifdef CR_RBUS_MASTER_STATS_EN
      stat_q       <= '0;
`endif
    end else begin
`ifdef CR_RBUS_MASTER_STATS_EN
      stat_q <= '0;
      if (ret_valid && !((state_q == WAIT) && ret_match))
        stat_q[STAT_DROP] <= 1'b1;
`endif
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            addr_q      <= req_addr;
            wr_q        <= req_wr;
            ring_q      <= launch_pkt;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= LAUNCH;
          end
        end

        LAUNCH: begin
          ring_q  <= '0;
          state_q <= WAIT;
        end

        WAIT: begin
          // A return arriving in the expiry cycle still counts as a return.
          if (ret_match) begin
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= ring_status(rbus_ring_i.ack, rbus_ring_i.err);
            rsp_rdata_q  <= (!wr_q && rbus_ring_i.ack && !rbus_ring_i.err)
                            ? rbus_ring_i.rd_data : 32'h0;
            state_q      <= RESP;
`ifdef CR_RBUS_MASTER_STATS_EN
            if (!rbus_ring_i.ack)
              stat_q[STAT_NOACK] <= 1'b1;
            else if (!rbus_ring_i.err)
              stat_q[STAT_OK] <= 1'b1;
`endif
          end else if (tmo_expired) begin
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= RBUS_ST_TIMEOUT;
            rsp_rdata_q  <= 32'h0;
            state_q      <= RESP;
`ifdef CR_RBUS_MASTER_STATS_EN
            stat_q[STAT_TIMEOUT] <= 1'b1;
`endif
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_status  = rsp_status_q;
  assign rbus_ring_o = ring_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_cr_rbus_ring_master.sv
`ifndef N_RBUS_ADDR_BITS
`define N_RBUS_ADDR_BITS 12
`endif

module tb_cr_rbus_ring_master;
  import cr_structs::*;

  localparam int AW  = `N_RBUS_ADDR_BITS;
  localparam int TMO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_status;
  rbus_ring_t    rbus_ring_o;
  rbus_ring_t    rbus_ring_i;
  logic          busy;

  int tests_run    = 0;
  int tests_failed = 0;

  cr_rbus_ring_master #(
    .TIMEOUT_CYCLES (TMO),
    .TO_W           (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_status  (rsp_status),
    .rbus_ring_o (rbus_ring_o),
    .rbus_ring_i (rbus_ring_i),
    .busy        (busy)
  );

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  // Issue one request, play the ring (optional stray packet at bad_at,
  // correct return after lat cycles, lat==0 means no return) and check the
  // completion fields.
  task automatic run_txn(input string name, input logic wr, input logic [AW-1:0] addr,
                         input logic [31:0] wdata, input int lat, input logic r_ack,
                         input logic r_err, input logic [31:0] r_data,
                         input logic [1:0] exp_st, input logic [31:0] exp_rd,
                         input int bad_at);
    rbus_ring_t exp_launch;
    rbus_ring_t ret;
    rbus_ring_t stray;
    int waited;
    int n_wait;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_req_ready: got %b want 1", name, req_ready);
    end

    exp_launch         = '0;
    exp_launch.addr    = addr;
    exp_launch.wr_strb = wr;
    exp_launch.rd_strb = ~wr;
    exp_launch.wr_data = wdata;
    ret         = exp_launch;
    ret.rd_data = r_data;
    ret.ack     = r_ack;
    ret.err     = r_err;
    stray       = ret;
    stray.addr  = addr ^ AW'(1);

    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    tests_run++;
    if (rbus_ring_o !== exp_launch) begin
      tests_failed++;
      $display("FAIL %s_launch: got %h want %h", name, rbus_ring_o, exp_launch);
    end
    tests_run++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_launch_flags: req_ready=%b busy=%b want 0/1", name, req_ready, busy);
    end

    tick();
    n_wait = (lat == 0) ? TMO + 1 : lat;
    for (int t = 1; t < n_wait; t++) begin
      rbus_ring_i = '0;
      if (t == bad_at) rbus_ring_i = stray;
      tests_run++;
      if (rsp_valid !== 1'b0 || rbus_ring_o !== '0) begin
        tests_failed++;
        $display("FAIL %s_wait_t%0d: rsp_valid=%b ring_o=%h want 0/0", name, t, rsp_valid, rbus_ring_o);
      end
      tick();
    end
    rbus_ring_i = '0;
    if (lat != 0) begin
      rbus_ring_i = ret;
      tick();
      rbus_ring_i = '0;
    end

    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_status !== exp_st || rsp_rdata !== exp_rd) begin
      tests_failed++;
      $display("FAIL %s_rsp: valid=%b status=%b rdata=%h want 1 %b %h",
               name, rsp_valid, rsp_status, rsp_rdata, exp_st, exp_rd);
    end
  endtask

  // Hold the completion for 'hold' cycles, then accept it.
  task automatic finish_rsp(input string name, input int hold,
                            input logic [1:0] exp_st, input logic [31:0] exp_rd);
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_status !== exp_st || rsp_rdata !== exp_rd ||
          req_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s_hold_%0d: valid=%b status=%b rdata=%h req_ready=%b want 1 %b %h 0",
                 name, i, rsp_valid, rsp_status, rsp_rdata, req_ready, exp_st, exp_rd);
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tests_run++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_accept: valid=%b req_ready=%b busy=%b want 0 1 0",
               name, rsp_valid, req_ready, busy);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests_run++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 ||
        rsp_status !== 2'b00 || rbus_ring_o !== '0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: rdy=%b vld=%b rdata=%h st=%b ring=%h busy=%b want all 0",
               req_ready, rsp_valid, rsp_rdata, rsp_status, rbus_ring_o, busy);
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_write();
    run_txn("wr010", 1'b1, AW'('h010), 32'hDEADBEEF, 5, 1'b1, 1'b0, 32'h0,
            2'b00, 32'h0, 0);
    finish_rsp("wr010", 0, 2'b00, 32'h0);
  endtask

  task automatic test_read();
    run_txn("rd020", 1'b0, AW'('h020), 32'h0, 3, 1'b1, 1'b0, 32'h12345678,
            2'b00, 32'h12345678, 0);
    finish_rsp("rd020", 0, 2'b00, 32'h12345678);
  endtask

  task automatic test_noack();
    run_txn("rd3f0", 1'b0, AW'('h3F0), 32'h0, 4, 1'b0, 1'b0, 32'h0,
            2'b01, 32'h0, 0);
    finish_rsp("rd3f0", 0, 2'b01, 32'h0);
  endtask

  task automatic test_resp_err();
    run_txn("rderr", 1'b0, AW'('h050), 32'h0, 2, 1'b1, 1'b1, 32'h0000AAAA,
            2'b11, 32'h0, 0);
    finish_rsp("rderr", 0, 2'b11, 32'h0);
  endtask

  task automatic test_drop_mismatch();
    run_txn("rdstray", 1'b0, AW'('h040), 32'h0, 6, 1'b1, 1'b0, 32'hCAFEF00D,
            2'b00, 32'hCAFEF00D, 2);
    finish_rsp("rdstray", 0, 2'b00, 32'hCAFEF00D);
  endtask

  task automatic test_timeout();
    rbus_ring_t late;
    run_txn("tmo", 1'b0, AW'('h060), 32'h0, 0, 1'b0, 1'b0, 32'h0,
            2'b10, 32'h0, 0);
    late         = '0;
    late.addr    = AW'('h060);
    late.rd_strb = 1'b1;
    late.ack     = 1'b1;
    late.rd_data = 32'h55AA55AA;
    rbus_ring_i  = late;
    tick();
    rbus_ring_i  = '0;
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_status !== 2'b10 || rsp_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL tmo_late_in_resp: valid=%b st=%b rdata=%h want 1 10 0",
               rsp_valid, rsp_status, rsp_rdata);
    end
    finish_rsp("tmo", 0, 2'b10, 32'h0);
    rbus_ring_i = late;
    tick();
    rbus_ring_i = '0;
    tick();
    tests_run++;
    if (rsp_valid !== 1'b0 || rbus_ring_o !== '0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL tmo_late_in_idle: valid=%b ring=%h busy=%b want 0 0 0",
               rsp_valid, rbus_ring_o, busy);
    end
  endtask

  task automatic test_back_to_back_race();
    run_txn("race", 1'b1, AW'('h070), 32'h0BADF00D, TMO, 1'b1, 1'b0, 32'h0,
            2'b00, 32'h0, 0);
    finish_rsp("race", 10, 2'b00, 32'h0);
  endtask

  task automatic test_reset_mid_wait();
    rbus_ring_t ret;
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = AW'('h080);
    req_wdata = 32'h0;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ret         = '0;
    ret.addr    = AW'('h080);
    ret.rd_strb = 1'b1;
    ret.ack     = 1'b1;
    ret.rd_data = 32'h11112222;
    rbus_ring_i = ret;
    tests_run++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstwait_first: valid=%b req_ready=%b want 0 0", rsp_valid, req_ready);
    end
    tick();
    rbus_ring_i = '0;
    tests_run++;
    if (rbus_ring_o !== '0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstwait_second: ring=%h req_ready=%b valid=%b want 0 1 0",
               rbus_ring_o, req_ready, rsp_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (rsp_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL rstwait_no_rsp_%0d: valid=%b want 0", i, rsp_valid);
      end
    end
    run_txn("after_rst", 1'b1, AW'('h090), 32'h01020304, 1, 1'b1, 1'b0, 32'h0,
            2'b00, 32'h0, 0);
    finish_rsp("after_rst", 0, 2'b00, 32'h0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_wr      = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    rsp_ready   = 1'b0;
    rbus_ring_i = '0;

    test_reset();
    test_write();
    test_read();
    test_noack();
    test_resp_err();
    test_drop_mismatch();
    test_timeout();
    test_back_to_back_race();
    test_reset_mid_wait();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
